timer_bus_arbiter: RTL and testbench

//  Shares one APB-style timer slave port (sel/enable/write/addr/wdata -> rdata/ready/slverr)

---
 rtl/timer_arb_pkg.sv | 25 ++
 rtl/timer_bus_arbiter_rr_pick.sv | 27 ++
 rtl/timer_bus_arbiter.sv | 154 +++++++++++++++
 tb/tb_timer_bus_arbiter.sv | 273 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/timer_arb_pkg.sv
// Timer bus arbiter shared types: FSM states, timer register map,
// default widths and the round-robin wrap helper.
package timer_arb_pkg;

  typedef enum logic [1:0] {
    ARB_IDLE,
    ARB_SETUP,
    ARB_ACCESS,
    ARB_DONE
  } arb_state_e;

  localparam logic [1:0] TMR_STATUS = 2'd0;
  localparam logic [1:0] TMR_GOAL   = 2'd1;
  localparam logic [1:0] TMR_CURR   = 2'd2;

  localparam int DEF_NREQ    = 2;
  localparam int DEF_ADDR_W  = 2;
  localparam int DEF_DATA_W  = 8;
  localparam int DEF_TIMEOUT = 16;

  function automatic int rr_next(input int idx, input int n);
    return (idx + 1) % n;
  endfunction

endpackage

// File: rtl/timer_bus_arbiter_rr_pick.sv
// Round-robin picker: first valid requester at or after ptr,
// wrapping past NREQ-1 back to 0.
module rr_pick #(
  parameter int NREQ  = 2,
  parameter int IDX_W = $clog2(NREQ)
) (
  input  logic [NREQ-1:0]  valid,
  input  logic [IDX_W-1:0] ptr,
  output logic [NREQ-1:0]  grant,
  output logic [IDX_W-1:0] idx,
  output logic             any_valid
);

  always_comb begin
    grant     = '0;
    idx       = '0;
    any_valid = 1'b0;
    for (int k = 0; k < NREQ; k++) begin
      if (!any_valid && valid[(int'(ptr) + k) % NREQ]) begin
        grant[(int'(ptr) + k) % NREQ] = 1'b1;
        idx       = IDX_W'((int'(ptr) + k) % NREQ);
        any_valid = 1'b1;
      end
    end
  end

endmodule

// File: rtl/timer_bus_arbiter.sv
// Round-robin share of one APB-style timer slave among NREQ masters.
// Define TIMER_ARB_TIMEOUT_EN to bound the ACCESS phase by TIMEOUT.
module timer_bus_arbiter
  import timer_arb_pkg::*;
#(
  parameter int NREQ    = DEF_NREQ,
  parameter int ADDR_W  = DEF_ADDR_W,
  parameter int DATA_W  = DEF_DATA_W,
  parameter int TIMEOUT = DEF_TIMEOUT
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic [NREQ-1:0]        req_valid,
  input  logic [NREQ-1:0]        req_write,
  input  logic [NREQ*ADDR_W-1:0] req_addr,
  input  logic [NREQ*DATA_W-1:0] req_wdata,
  output logic [NREQ-1:0]        req_done,
  output logic [DATA_W-1:0]      rsp_rdata,
  output logic                   rsp_err,
  output logic                   m_sel,
  output logic                   m_enable,
  output logic                   m_write,
  output logic [ADDR_W-1:0]      m_addr,
  output logic [DATA_W-1:0]      m_wdata,
  input  logic [DATA_W-1:0]      m_rdata,
  input  logic                   m_ready,
  input  logic                   m_slverr
);

  localparam int IDX_W = $clog2(NREQ);

  arb_state_e        state, state_nx;
  logic [IDX_W-1:0]  rr_ptr, gnt_idx, pick_idx;
  logic [NREQ-1:0]   gnt_oh, pick_oh;
  logic              pick_any;
  logic              lat_write;
  logic [ADDR_W-1:0] lat_addr;
  logic [DATA_W-1:0] lat_wdata;
  logic              acc_tmo;

  rr_pick #(
    .NREQ  (NREQ),
    .IDX_W (IDX_W)
  ) u_pick (
    .valid     (req_valid),
    .ptr       (rr_ptr),
    .grant     (pick_oh),
    .idx       (pick_idx),
    .any_valid (pick_any)
  );

`ifdef TIMER_ARB_TIMEOUT_EN
  logic [7:0] acc_cnt;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset)
      acc_cnt <= '0;
    else if (state == ARB_SETUP)
      acc_cnt <= '0;
    else if (state == ARB_ACCESS)
      acc_cnt <= acc_cnt + 8'd1;
  end

  // the TIMEOUT-th ACCESS cycle without ready ends the transfer
  assign acc_tmo = !m_ready
                && (acc_cnt == 8'(TIMEOUT - 1));
`else
  localparam int unused_timeout = TIMEOUT;
  assign acc_tmo = 1'b0;
`endif

  always_ff @(posedge clk or negedge reset) begin
    if (!reset)
      state <= ARB_IDLE;
    else
      state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    m_sel    = 1'b0;
    m_enable = 1'b0;
    m_write  = 1'b0;
    m_addr   = '0;
    m_wdata  = '0;
    req_done = '0;
    unique case (state)
      ARB_IDLE: begin
        if (pick_any)
          state_nx = ARB_SETUP;
      end
      ARB_SETUP: begin
        m_sel    = 1'b1;
        m_write  = lat_write;
        m_addr   = lat_addr;
        m_wdata  = lat_wdata;
        state_nx = ARB_ACCESS;
      end
      ARB_ACCESS: begin
        m_sel    = 1'b1;
        m_enable = 1'b1;
        m_write  = lat_write;
        m_addr   = lat_addr;
        m_wdata  = lat_wdata;
        if (m_ready || acc_tmo)
          state_nx = ARB_DONE;
      end
      ARB_DONE: begin
        req_done = gnt_oh;
        state_nx = ARB_IDLE;
      end
      default: state_nx = ARB_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      rr_ptr    <= '0;
      gnt_idx   <= '0;
      gnt_oh    <= '0;
      lat_write <= 1'b0;
      lat_addr  <= '0;
      lat_wdata <= '0;
      rsp_rdata <= '0;
      rsp_err   <= 1'b0;
    end else begin
      unique case (state)
        ARB_IDLE: begin
          if (pick_any) begin
            gnt_idx   <= pick_idx;
            gnt_oh    <= pick_oh;
            lat_write <= req_write[pick_idx];
            lat_addr  <= req_addr[int'(pick_idx)*ADDR_W +: ADDR_W];
            lat_wdata <= req_wdata[int'(pick_idx)*DATA_W +: DATA_W];
          end
        end
        ARB_ACCESS: begin
          if (m_ready) begin
            rsp_rdata <= lat_write ? '0 : m_rdata;
            rsp_err   <= m_slverr;
          end else if (acc_tmo) begin
            rsp_rdata <= '0;
            rsp_err   <= 1'b1;
          end
        end
        ARB_DONE: begin
          rr_ptr <= IDX_W'(rr_next(int'(gnt_idx), NREQ));
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_timer_bus_arbiter.sv
// Directed and random transfers against a round-robin reference model
// of the timer bus arbiter; slave responses are driven from the bench.
module tb_timer_bus_arbiter;
  import timer_arb_pkg::*;

  localparam int NREQ = 3;
  localparam int AW   = 2;
  localparam int DW   = 8;
  localparam int TMO  = 4;

  logic              clk = 1'b0;
  logic              reset;
  logic [NREQ-1:0]   rv;
  logic [NREQ-1:0]   rw;
  logic [NREQ*AW-1:0] ra;
  logic [NREQ*DW-1:0] rwd;
  logic [NREQ-1:0]   req_done;
  logic [DW-1:0]     rsp_rdata;
  logic              rsp_err;
  logic              m_sel, m_enable, m_write;
  logic [AW-1:0]     m_addr;
  logic [DW-1:0]     m_wdata;
  logic [DW-1:0]     m_rdata;
  logic              m_ready, m_slverr;

  int n_cmp = 0;
  int n_err = 0;
  int ptr   = 0;
  logic [DW-1:0] exp_rd;
  logic          exp_er;

  always #5 clk = ~clk;

  timer_bus_arbiter #(
    .NREQ    (NREQ),
    .ADDR_W  (AW),
    .DATA_W  (DW),
    .TIMEOUT (TMO)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .req_valid (rv),
    .req_write (rw),
    .req_addr  (ra),
    .req_wdata (rwd),
    .req_done  (req_done),
    .rsp_rdata (rsp_rdata),
    .rsp_err   (rsp_err),
    .m_sel     (m_sel),
    .m_enable  (m_enable),
    .m_write   (m_write),
    .m_addr    (m_addr),
    .m_wdata   (m_wdata),
    .m_rdata   (m_rdata),
    .m_ready   (m_ready),
    .m_slverr  (m_slverr)
  );

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // spec rule: first valid requester at/after the pointer, wrapping
  function automatic int pick(input logic [NREQ-1:0] v, input int p);
    for (int k = 0; k < NREQ; k++)
      if (v[(p + k) % NREQ]) return (p + k) % NREQ;
    return -1;
  endfunction

  task automatic set_req(input int i, input logic w,
                         input logic [AW-1:0] a,
                         input logic [DW-1:0] d);
    rv[i] = 1'b1;
    rw[i] = w;
    ra[i*AW +: AW] = a;
    rwd[i*DW +: DW] = d;
  endtask

  task automatic chk_bus_idle(input string tag);
    chk({tag, "_sel"},   m_sel,    0);
    chk({tag, "_en"},    m_enable, 0);
    chk({tag, "_write"}, m_write,  0);
    chk({tag, "_addr"},  m_addr,   0);
    chk({tag, "_wdata"}, m_wdata,  0);
  endtask

  task automatic chk_reset_outs(input string tag);
    chk({tag, "_done"},  req_done,  0);
    chk({tag, "_rdata"}, rsp_rdata, 0);
    chk({tag, "_err"},   rsp_err,   0);
    chk_bus_idle(tag);
  endtask

  // one full transfer starting in an IDLE cycle; wt = ready-low cycles
  task automatic xfer(input int wt, input logic [DW-1:0] rd,
                      input logic er, output int g);
    logic          w;
    logic [AW-1:0] a;
    logic [DW-1:0] d;
    g = pick(rv, ptr);
    if (g < 0) begin
      n_err++;
      $display("FAIL xfer: no pending request to grant");
      return;
    end
    w = rw[g];
    a = ra[g*AW +: AW];
    d = rwd[g*DW +: DW];
    m_ready = 1'b0;
    tick();
    chk("setup_sel",   m_sel,    1);
    chk("setup_en",    m_enable, 0);
    chk("setup_write", m_write,  {31'd0, w});
    chk("setup_addr",  m_addr,   {30'd0, a});
    chk("setup_wdata", m_wdata,  {24'd0, d});
    chk("setup_done",  req_done, 0);
    ra[g*AW +: AW]  = AW'($urandom);
    rwd[g*DW +: DW] = DW'($urandom);
    rw[g] = 1'($urandom);
    if ($urandom_range(0, 3) == 0) rv[g] = 1'b0;
    tick();
    for (int i = 0; i <= wt; i++) begin
      if (i == wt) begin
        m_ready  = 1'b1;
        m_rdata  = rd;
        m_slverr = er;
      end else begin
        m_ready  = 1'b0;
        m_rdata  = DW'($urandom);
        m_slverr = 1'($urandom);
      end
      chk("acc_sel",   m_sel,    1);
      chk("acc_en",    m_enable, 1);
      chk("acc_write", m_write,  {31'd0, w});
      chk("acc_addr",  m_addr,   {30'd0, a});
      chk("acc_wdata", m_wdata,  {24'd0, d});
      chk("acc_done",  req_done, 0);
      tick();
    end
    m_ready  = 1'b0;
    m_rdata  = DW'($urandom);
    m_slverr = 1'($urandom);
    exp_rd = w ? '0 : rd;
    exp_er = er;
    chk("done_vec",   req_done,  32'(1) << g);
    chk("done_rdata", rsp_rdata, {24'd0, exp_rd});
    chk("done_err",   rsp_err,   {31'd0, exp_er});
    chk("done_sel",   m_sel,     0);
    chk("done_en",    m_enable,  0);
    rv[g] = 1'b0;
    ptr = (g + 1) % NREQ;
    tick();
    chk("idle_done",  req_done,  0);
    chk("hold_rdata", rsp_rdata, {24'd0, exp_rd});
    chk("hold_err",   rsp_err,   {31'd0, exp_er});
    chk_bus_idle("idle");
  endtask

  initial begin
    int g;
    int seen;
    reset    = 1'b0;
    rv       = '0;
    rw       = '0;
    ra       = '0;
    rwd      = '0;
    m_rdata  = '0;
    m_ready  = 1'b0;
    m_slverr = 1'b0;
    tick();
    chk_reset_outs("reset");
    tick();
    reset = 1'b1;

    // write to GOAL, slave ready at once
    set_req(0, 1'b1, TMR_GOAL, 8'h2A);
    xfer(0, 8'h00, 1'b0, g);

    // two readers contend: alternating grants
    set_req(0, 1'b0, TMR_STATUS, 8'h00);
    set_req(1, 1'b0, TMR_GOAL, 8'h00);
    for (int t = 0; t < 4; t++) begin
      xfer(0, DW'($urandom), 1'b0, g);
      if (t < 2) set_req(g, 1'b0, AW'(g), 8'h00);
    end
    rv = '0;

    // slow slave: three wait states
    set_req(2, 1'b0, TMR_CURR, 8'h00);
    xfer(3, 8'h11, 1'b0, g);

    // slave error on a write
    set_req(1, 1'b1, TMR_CURR, 8'h99);
    xfer(0, 8'hEE, 1'b1, g);

    for (int n = 0; n < 40; n++) begin
      for (int i = 0; i < NREQ; i++)
        if (!rv[i] && $urandom_range(0, 1) == 1)
          set_req(i, 1'($urandom), AW'($urandom), DW'($urandom));
      if (rv == '0)
        set_req($urandom_range(0, NREQ - 1), 1'($urandom),
                AW'($urandom), DW'($urandom));
      xfer($urandom_range(0, 3), DW'($urandom),
           1'($urandom_range(0, 1)), g);
    end

    // slave never ready
    rv = '0;
    set_req(0, 1'b0, TMR_CURR, 8'h00);
    g = pick(rv, ptr);
    m_ready = 1'b0;
    m_rdata = 8'h5A;
    tick();
    tick();
`ifdef TIMER_ARB_TIMEOUT_EN
    for (int i = 0; i < TMO; i++) begin
      chk("tmo_en",   m_enable, 1);
      chk("tmo_wait", req_done, 0);
      tick();
    end
    chk("tmo_done",  req_done,  32'(1) << g);
    chk("tmo_err",   rsp_err,   1);
    chk("tmo_rdata", rsp_rdata, 0);
`else
    seen = 0;
    for (int i = 0; i < 100; i++) begin
      if (req_done != '0) seen++;
      tick();
    end
    chk("no_tmo_done", seen, 0);
    chk("no_tmo_en",   m_enable, 1);
`endif
    rv = '0;
    reset = 1'b0;
    tick();
    chk_reset_outs("reset2");
    reset = 1'b1;
    ptr = 0;

    // reset during ACCESS aborts with no done
    set_req(1, 1'b0, TMR_STATUS, 8'h00);
    tick();
    tick();
    chk("abort_en", m_enable, 1);
    #2;
    reset = 1'b0;
    #1;
    chk_reset_outs("abort");
    set_req(0, 1'b1, TMR_GOAL, 8'h3C);
    tick();
    chk("abort_nodone", req_done, 0);
    reset = 1'b1;
    ptr = 0;
    xfer(1, 8'h77, 1'b0, g);
    xfer(0, 8'h44, 1'b0, g);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_err);
    $finish;
  end

endmodule
